// File: rtl/img_gen_pkg.sv
// Shared encodings and helpers for the image pattern generator family.
package img_gen_pkg;

  // Test pattern select values, latched at frame start.
  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_MOVE  = 2'd3
  } mode_e;

  // Generator run state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/img_timing_cnt.sv
// Raster h/v counters with sync / data-enable decode and active coordinates.
// Decode outputs are combinational from the counter registers.
module img_timing_cnt
  import img_gen_pkg::*;
#(
  parameter int unsigned ACTIVE_IW = 640,
  parameter int unsigned ACTIVE_IH = 480,
  parameter int unsigned TOTAL_IW  = 800,
  parameter int unsigned TOTAL_IH  = 600,
  parameter int unsigned H_START   = 50,
  parameter int unsigned V_START   = 30,
  parameter int unsigned VS_LEN    = 4,
  // Wide enough to hold TOTAL itself so H_START+ACTIVE never truncates.
  parameter int unsigned HW        = clog2(TOTAL_IW + 1),
  parameter int unsigned VW        = clog2(TOTAL_IH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          vs_o,
  output logic          de_o,
  output logic          last_px_o,
  output logic          frame_end_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;
  logic          h_act, v_act;

  assign h_last = (h_q == HW'(TOTAL_IW - 1));
  assign v_last = (v_q == VW'(TOTAL_IH - 1));

  // Next counter values: h wraps every line, v advances on h wrap.
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  // Counters are held at the origin whenever the generator is not running.
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Timing decode from the current counter values.
  always_comb begin
    h_act       = (h_q >= HW'(H_START)) && (h_q < HW'(H_START + ACTIVE_IW));
    v_act       = (v_q >= VW'(V_START)) && (v_q < VW'(V_START + ACTIVE_IH));
    x_o         = h_q - HW'(H_START);
    y_o         = v_q - VW'(V_START);
    vs_o        = run_i && (v_q < VW'(VS_LEN));
    de_o        = run_i && h_act && v_act;
    last_px_o   = de_o && (x_o == HW'(ACTIVE_IW - 1)) && (y_o == VW'(ACTIVE_IH - 1));
    frame_end_o = run_i && h_last && v_last;
  end

endmodule

// File: rtl/img_pattern_gen.sv
// Parametrised DVP-style test image source: four patterns, frame counter,
// end-of-frame pulse and frame-aligned start/stop.
module img_pattern_gen
  import img_gen_pkg::*;
#(
  parameter int unsigned ACTIVE_IW = 640,
  parameter int unsigned ACTIVE_IH = 480,
  parameter int unsigned TOTAL_IW  = 800,
  parameter int unsigned TOTAL_IH  = 600,
  parameter int unsigned H_START   = 50,
  parameter int unsigned V_START   = 30,
  parameter int unsigned VS_LEN    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHK_LOG2  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              pre_vs,
  output logic              pre_de,
  output logic [DATA_W-1:0] pre_data,
  output logic [15:0]       frame_cnt,
  output logic              eof,
  output logic              busy
);

  localparam int unsigned HW    = clog2(TOTAL_IW + 1);
  localparam int unsigned VW    = clog2(TOTAL_IH + 1);
  localparam int unsigned BAR_W = ACTIVE_IW / 8;
  localparam int unsigned BW    = clog2(BAR_W);

  if (H_START + ACTIVE_IW > TOTAL_IW) begin : g_err_h
    $error("img_pattern_gen: H_START + ACTIVE_IW exceeds TOTAL_IW");
  end
  if (V_START + ACTIVE_IH > TOTAL_IH) begin : g_err_v
    $error("img_pattern_gen: V_START + ACTIVE_IH exceeds TOTAL_IH");
  end
  if (VS_LEN > V_START) begin : g_err_vs
    $error("img_pattern_gen: VS_LEN overlaps the active area");
  end
  if (DATA_W < 4) begin : g_err_dw
    $error("img_pattern_gen: DATA_W must be at least 4");
  end
  if (ACTIVE_IW < 8) begin : g_err_aw
    $error("img_pattern_gen: ACTIVE_IW must be at least 8");
  end

  state_e            state_q, state_d;
  logic              run, frame_start;
  logic [HW-1:0]     x;
  logic [VW-1:0]     y;
  logic              vs_raw, de_raw, last_px, frame_end, last_col;
  mode_e             mode_q;
  logic [15:0]       frame_cnt_q, frame_cnt_d, base_q;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [BW-1:0]     bar_px_q, bar_px_d;
  logic [HW-1:0]     x_sh;
  logic [VW-1:0]     y_sh;
  logic [DATA_W-1:0] x_px, pix;
  logic              pre_vs_q, pre_de_q, eof_q, busy_q;
  logic [DATA_W-1:0] pre_data_q;
  logic              unused_bits;

  img_timing_cnt #(
    .ACTIVE_IW (ACTIVE_IW),
    .ACTIVE_IH (ACTIVE_IH),
    .TOTAL_IW  (TOTAL_IW),
    .TOTAL_IH  (TOTAL_IH),
    .H_START   (H_START),
    .V_START   (V_START),
    .VS_LEN    (VS_LEN),
    .HW        (HW),
    .VW        (VW)
  ) u_timing (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .x_o         (x),
    .y_o         (y),
    .vs_o        (vs_raw),
    .de_o        (de_raw),
    .last_px_o   (last_px),
    .frame_end_o (frame_end)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: en is only acted on at frame boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counter run and the frame-start strobe that relatches mode.
  always_comb begin
    run         = (state_q == RUN);
    frame_start = 1'b0;
    unique case (state_q)
      IDLE:    frame_start = en;
      RUN:     frame_start = frame_end && en;
      default: frame_start = 1'b0;
    endcase
    frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter and per-frame latches; the moving ramp uses the count
  // the new frame starts with.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_RAMP;
      frame_cnt_q <= '0;
      base_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      if (frame_start) begin
        mode_q <= mode_e'(mode);
        base_q <= frame_cnt_d;
      end
    end
  end

  assign last_col = (x == HW'(ACTIVE_IW - 1));

  // Bar tracking: counts BAR_W pixels per bar, saturating so the remainder
  // pixels stay in bar 7; clears outside active video and after each line.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    if (!de_raw || last_col) begin
      bar_idx_d = '0;
      bar_px_d  = '0;
    end else if (bar_px_q == BW'(BAR_W - 1)) begin
      bar_px_d = '0;
      if (bar_idx_q != 3'd7) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end else begin
      bar_px_d = bar_px_q + BW'(1);
    end
  end

  // Bar state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_idx_q <= '0;
      bar_px_q  <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
    end
  end

  assign x_sh        = x >> CHK_LOG2;
  assign y_sh        = y >> CHK_LOG2;
  assign unused_bits = ^{x, y, x_sh, y_sh, base_q};

  // Pattern mux from the latched mode.
  always_comb begin
    x_px = DATA_W'(x);
    pix  = '0;
    unique case (mode_q)
      MODE_RAMP:  pix = x_px;
      MODE_BARS:  pix = {bar_idx_q, {(DATA_W - 3){bar_idx_q[0]}}};
      MODE_CHECK: pix = (x_sh[0] ^ y_sh[0]) ? '1 : '0;
      MODE_MOVE:  pix = x_px + DATA_W'(base_q);
      default:    pix = '0;
    endcase
  end

  // Output stage, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_vs_q   <= 1'b0;
      pre_de_q   <= 1'b0;
      pre_data_q <= '0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pre_vs_q   <= vs_raw;
      pre_de_q   <= de_raw;
      pre_data_q <= de_raw ? pix : '0;
      eof_q      <= last_px;
      busy_q     <= run;
    end
  end

  assign pre_vs    = pre_vs_q;
  assign pre_de    = pre_de_q;
  assign pre_data  = pre_data_q;
  assign frame_cnt = frame_cnt_q;
  assign eof       = eof_q;
  assign busy      = busy_q;

endmodule
